// File: rtl/wb_slave_regbank_pkg.sv
// Shared Wishbone types for burst-capable slaves.
// Provides FSM state, cycle-type and burst-type encodings.
package wb_pkg;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_t;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational Wishbone burst address step: next(cur_adr, bte).
// Ports: cur_adr_i current word index, bte_i burst type, next_adr_o next index.
module wb_burst_addr_gen
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] cur_adr_i,
  input  logic [1:0]            bte_i,
  output logic [ADDR_WIDTH-1:0] next_adr_o
);

  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] wrap_m;

  // wrap_m marks the bits allowed to count; the rest are held.
  always_comb begin
    inc    = cur_adr_i + ADDR_WIDTH'(1);
    wrap_m = '1;
    unique case (bte_t'(bte_i))
      BTE_LINEAR: wrap_m = '1;
      BTE_WRAP4:  wrap_m = ADDR_WIDTH'(3);
      BTE_WRAP8:  wrap_m = ADDR_WIDTH'(7);
      BTE_WRAP16: wrap_m = ADDR_WIDTH'(15);
    endcase
    next_adr_o = (cur_adr_i & ~wrap_m) | (inc & wrap_m);
  end

endmodule

// File: rtl/wb_slave_regbank.sv
// Wishbone B4 classic/burst slave over a bank of registers.
// Ports: wb slave (adr/dat/sel/we/stb/cyc/cti/bte/ack/err), regs_o, wr_pulse_o.
module wb_slave_regbank
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int GRANULE      = 8,
  parameter int REGISTER_NUM = 16,
  parameter logic [REGISTER_NUM-1:0] RO_MASK = '0,
  localparam int SEL_WIDTH   = DATA_WIDTH / GRANULE
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_WIDTH-1:0]  adr_i,
  input  logic [DATA_WIDTH-1:0]  dat_i,
  output logic [DATA_WIDTH-1:0]  dat_o,
  input  logic [SEL_WIDTH-1:0]   sel_i,
  input  logic                   we_i,
  input  logic                   stb_i,
  input  logic                   cyc_i,
  input  logic [2:0]             cti_i,
  input  logic [1:0]             bte_i,
  output logic                   ack_o,
  output logic                   err_o,
  output logic [REGISTER_NUM*DATA_WIDTH-1:0] regs_o,
  output logic [REGISTER_NUM-1:0] wr_pulse_o
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_adr_q, cur_adr_d;
  logic [ADDR_WIDTH-1:0]   next_adr;
  logic [ADDR_WIDTH-1:0]   rd_adr;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   lane_mask;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic [REGISTER_NUM-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [REGISTER_NUM];

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {1'b0, a} < (ADDR_WIDTH+1)'(REGISTER_NUM);
  endfunction

  wb_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .cur_adr_i (cur_adr_q),
    .bte_i     (bte_i),
    .next_adr_o(next_adr)
  );

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      lane_mask[i*GRANULE+:GRANULE] = {GRANULE{sel_i[i]}};
    end
  end

  // In IDLE the first beat reads at adr_i; inside a burst the
  // following beat is prefetched from the generated address.
  assign rd_adr = (state_q == IDLE) ? adr_i : next_adr;

  always_comb begin
    rd_data = '0;
    for (int n = 0; n < REGISTER_NUM; n++) begin
      if (rd_adr == ADDR_WIDTH'(n)) begin
        rd_data = regs_q[n];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_adr_d = cur_adr_q;
    dat_d     = dat_q;
    ack_d     = ack_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    if (!cyc_i) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stb_i) begin
            state_d   = ACK;
            cur_adr_d = adr_i;
            dat_d     = rd_data & lane_mask;
            ack_d     = in_range(adr_i);
            err_d     = !in_range(adr_i);
          end
        end
        ACK: begin
          // stb_i low is a master wait state: everything holds.
          if (stb_i) begin
            wr_en = we_i & ack_q;
            if (cti_i == CTI_INCR) begin
              cur_adr_d = next_adr;
              dat_d     = rd_data & lane_mask;
              ack_d     = in_range(next_adr);
              err_d     = !in_range(next_adr);
            end else begin
              state_d = IDLE;
              ack_d   = 1'b0;
              err_d   = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Read-only registers still ack but neither change nor pulse.
  always_comb begin
    wr_pulse_d = '0;
    for (int n = 0; n < REGISTER_NUM; n++) begin
      wr_pulse_d[n] = wr_en & !RO_MASK[n] &
                      (cur_adr_q == ADDR_WIDTH'(n));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_adr_q  <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_pulse_q <= '0;
      for (int n = 0; n < REGISTER_NUM; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_adr_q  <= cur_adr_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      wr_pulse_q <= wr_pulse_d;
      for (int n = 0; n < REGISTER_NUM; n++) begin
        if (wr_pulse_d[n]) begin
          regs_q[n] <= (regs_q[n] & ~lane_mask) |
                       (dat_i & lane_mask);
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < REGISTER_NUM; n++) begin
      regs_o[n*DATA_WIDTH+:DATA_WIDTH] = regs_q[n];
    end
  end

  assign dat_o      = dat_q;
  assign ack_o      = ack_q & cyc_i & stb_i;
  assign err_o      = err_q & cyc_i & stb_i;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_wb_slave_regbank.sv
// Directed self-checking bench for wb_slave_regbank.
// Reg 1 is read-only; 16 registers of 32 bits.
module tb_wb_slave_regbank;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel_i = '0;
  logic        we_i  = 1'b0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic [2:0]  cti_i = '0;
  logic [1:0]  bte_i = '0;
  logic        ack_o;
  logic        err_o;
  logic [511:0] regs_o;
  logic [15:0] wr_pulse_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] bd [8];
  logic [2:0]  bc [8];
  logic [31:0] rd [8];
  logic        ak [8];
  logic        er [8];
  logic [15:0] wp [8];
  int          waits;
  logic        last_ack;

  always #5 clk_i = ~clk_i;

  wb_slave_regbank #(
    .RO_MASK(16'h0002)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .stb_i     (stb_i),
    .cyc_i     (cyc_i),
    .cti_i     (cti_i),
    .bte_i     (bte_i),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .regs_o    (regs_o),
    .wr_pulse_o(wr_pulse_o)
  );

  function automatic logic [31:0] reg_at(input int n);
    return regs_o[n*32+:32];
  endfunction

  task automatic run_burst(
    input logic        we,
    input logic [15:0] adr,
    input logic [1:0]  bte,
    input logic [3:0]  sel,
    input int          n
  );
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
    adr_i = adr; bte_i = bte; sel_i = sel;
    dat_i = bd[0]; cti_i = bc[0];
    waits = 0;
    @(negedge clk_i);
    while (!(ack_o | err_o) && waits < 4) begin
      waits++;
      @(negedge clk_i);
    end
    for (int i = 0; i < n; i++) begin
      ak[i] = ack_o; er[i] = err_o; rd[i] = dat_o;
      @(posedge clk_i); #1;
      if (i + 1 < n) begin
        dat_i = bd[i+1]; cti_i = bc[i+1];
        adr_i = 16'hFFFF;
      end else begin
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        cti_i = 3'b000;
      end
      @(negedge clk_i);
      wp[i] = wr_pulse_o;
    end
    last_ack = ack_o | err_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (regs_o !== '0) begin
      errors++; $display("FAIL reset_regs got %h want 0", regs_o);
    end
    checks++;
    if ({ack_o, err_o, dat_o, wr_pulse_o} !== '0) begin
      errors++;
      $display("FAIL reset_outs got ack %b err %b dat %h wp %h want 0",
               ack_o, err_o, dat_o, wr_pulse_o);
    end
  endtask

  task automatic test_classic();
    bd[0] = 32'h0; bc[0] = 3'b000;
    run_burst(1'b0, 16'd3, 2'b00, 4'hF, 1);
    checks++;
    if (waits !== 1 || ak[0] !== 1'b1 || er[0] !== 1'b0) begin
      errors++;
      $display("FAIL classic_rd_lat got waits %0d ack %b err %b want 1 1 0",
               waits, ak[0], er[0]);
    end
    checks++;
    if (rd[0] !== 32'h0 || wp[0] !== 16'h0) begin
      errors++;
      $display("FAIL classic_rd_data got dat %h wp %h want 0 0", rd[0], wp[0]);
    end
    bd[0] = 32'hDEADBEEF;
    run_burst(1'b1, 16'd2, 2'b00, 4'b0101, 1);
    checks++;
    if (ak[0] !== 1'b1 || wp[0] !== 16'h0004) begin
      errors++;
      $display("FAIL classic_wr got ack %b wp %h want 1 0004", ak[0], wp[0]);
    end
    checks++;
    if (reg_at(2) !== 32'h00AD00EF) begin
      errors++;
      $display("FAIL classic_wr_reg got %h want 00ad00ef", reg_at(2));
    end
    @(negedge clk_i);
    checks++;
    if (wr_pulse_o !== 16'h0) begin
      errors++; $display("FAIL pulse_width got %h want 0", wr_pulse_o);
    end
    run_burst(1'b0, 16'd2, 2'b00, 4'hF, 1);
    checks++;
    if (rd[0] !== 32'h00AD00EF) begin
      errors++; $display("FAIL readback got %h want 00ad00ef", rd[0]);
    end
    run_burst(1'b0, 16'd2, 2'b00, 4'b0011, 1);
    checks++;
    if (rd[0] !== 32'h000000EF) begin
      errors++; $display("FAIL readback_sel got %h want 000000ef", rd[0]);
    end
  endtask

  task automatic test_linear_burst();
    bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33; bd[3] = 32'h44;
    bc[0] = 3'b010; bc[1] = 3'b010; bc[2] = 3'b010; bc[3] = 3'b111;
    run_burst(1'b1, 16'd4, 2'b00, 4'hF, 4);
    checks++;
    if (waits !== 1) begin
      errors++; $display("FAIL lin_wr_lat got %0d want 1", waits);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ak[i] !== 1'b1 || wp[i] !== (16'h0010 << i) ||
          reg_at(4 + i) !== bd[i]) begin
        errors++;
        $display("FAIL lin_wr_beat%0d got ack %b wp %h reg %h want 1 %h %h",
                 i, ak[i], wp[i], reg_at(4 + i), 16'h0010 << i, bd[i]);
      end
    end
    checks++;
    if (last_ack !== 1'b0) begin
      errors++; $display("FAIL lin_wr_end got ack %b want 0", last_ack);
    end
    run_burst(1'b0, 16'd4, 2'b00, 4'hF, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ak[i] !== 1'b1 || rd[i] !== bd[i]) begin
        errors++;
        $display("FAIL lin_rd_beat%0d got ack %b dat %h want 1 %h",
                 i, ak[i], rd[i], bd[i]);
      end
    end
  endtask

  task automatic test_wrap4();
    logic [31:0] exp [4];
    exp[0] = 32'h33; exp[1] = 32'h44; exp[2] = 32'h11; exp[3] = 32'h22;
    bc[0] = 3'b010; bc[1] = 3'b010; bc[2] = 3'b010; bc[3] = 3'b111;
    run_burst(1'b0, 16'd6, 2'b01, 4'hF, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ak[i] !== 1'b1 || rd[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap4_beat%0d got ack %b dat %h want 1 %h",
                 i, ak[i], rd[i], exp[i]);
      end
    end
  endtask

  task automatic test_ro_and_bounds();
    bd[0] = 32'hFFFFFFFF; bc[0] = 3'b000;
    run_burst(1'b1, 16'd1, 2'b00, 4'hF, 1);
    checks++;
    if (ak[0] !== 1'b1 || wp[0] !== 16'h0 || reg_at(1) !== 32'h0) begin
      errors++;
      $display("FAIL ro_write got ack %b wp %h reg %h want 1 0 0",
               ak[0], wp[0], reg_at(1));
    end
    run_burst(1'b0, 16'd16, 2'b00, 4'hF, 1);
    checks++;
    if (er[0] !== 1'b1 || ak[0] !== 1'b0 || rd[0] !== 32'h0) begin
      errors++;
      $display("FAIL oob_read got err %b ack %b dat %h want 1 0 0",
               er[0], ak[0], rd[0]);
    end
    run_burst(1'b1, 16'd16, 2'b00, 4'hF, 1);
    checks++;
    if (er[0] !== 1'b1 || wp[0] !== 16'h0) begin
      errors++;
      $display("FAIL oob_write got err %b wp %h want 1 0", er[0], wp[0]);
    end
    bd[0] = 32'hA5A5A5A5; bd[1] = 32'h5A5A5A5A;
    bc[0] = 3'b010; bc[1] = 3'b111;
    run_burst(1'b1, 16'd15, 2'b00, 4'hF, 2);
    checks++;
    if (ak[0] !== 1'b1 || er[0] !== 1'b0 || wp[0] !== 16'h8000) begin
      errors++;
      $display("FAIL edge_beat0 got ack %b err %b wp %h want 1 0 8000",
               ak[0], er[0], wp[0]);
    end
    checks++;
    if (ak[1] !== 1'b0 || er[1] !== 1'b1 || wp[1] !== 16'h0) begin
      errors++;
      $display("FAIL edge_beat1 got ack %b err %b wp %h want 0 1 0",
               ak[1], er[1], wp[1]);
    end
    checks++;
    if (reg_at(15) !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL edge_reg15 got %h want a5a5a5a5", reg_at(15));
    end
  endtask

  task automatic test_abort();
    bd[0] = 32'h81; bd[1] = 32'h82;
    bc[0] = 3'b010; bc[1] = 3'b010;
    run_burst(1'b1, 16'd8, 2'b00, 4'hF, 2);
    checks++;
    if (last_ack !== 1'b0) begin
      errors++; $display("FAIL cyc_drop_ack got %b want 0", last_ack);
    end
    @(negedge clk_i);
    checks++;
    if (reg_at(8) !== 32'h81 || reg_at(9) !== 32'h82 ||
        reg_at(10) !== 32'h0 || wr_pulse_o !== 16'h0) begin
      errors++;
      $display("FAIL cyc_drop_regs got %h %h %h wp %h want 81 82 0 0",
               reg_at(8), reg_at(9), reg_at(10), wr_pulse_o);
    end
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'd12;
    sel_i = 4'hF; dat_i = 32'hC1; cti_i = 3'b010; bte_i = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (ack_o !== 1'b1) begin
      errors++; $display("FAIL rst_burst_ack got %b want 1", ack_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ack_o !== 1'b0 || wr_pulse_o !== 16'h0 || regs_o !== '0) begin
      errors++;
      $display("FAIL rst_burst got ack %b wp %h reg12 %h want 0 0 0",
               ack_o, wr_pulse_o, reg_at(12));
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (reg_at(12) !== 32'h0 || wr_pulse_o !== 16'h0) begin
      errors++;
      $display("FAIL rst_after got reg12 %h wp %h want 0 0",
               reg_at(12), wr_pulse_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_classic();
    test_linear_burst();
    test_wrap4();
    test_ro_and_bounds();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
